// File: rtl/wishbone_req_decoder.sv
// Wishbone request decoder.
// Registers a single host request, decodes the target field of the address and
// drives a one-hot strobe to either the CSR block or one of the DCOL matrix
// (double-column EOC) targets. The strobe is held until the muxed ack returns,
// a timeout expires, or the host drops its cycle.
module wishbone_req_decoder #(
    parameter int DCOL    = 5,   // number of matrix targets, 1..15
    parameter int TIMEOUT = 16   // strobe cycles without ack before error, 2..255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [7:0]      wb_adr_i,
    input  logic [7:0]      wb_dat_to_i,
    input  logic            wb_ack_i,
    output logic            wb_stb_csr_o,
    output logic [DCOL-1:0] wb_stb_matrix_o,
    output logic            wb_we_o,
    output logic [3:0]      wb_adr_o,
    output logic [7:0]      wb_dat_to_o,
    output logic            wb_busy_o,
    output logic            wb_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Counter value seen during the last permitted strobe cycle. The counter is
    // zero in the first strobe cycle, so it reads TIMEOUT-1 in cycle TIMEOUT and
    // would become TIMEOUT at the following edge.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t          state_reg, state_next;
    logic [7:0]      count_reg, count_next;
    logic            stb_csr_reg, stb_csr_next;
    logic [DCOL-1:0] stb_matrix_reg, stb_matrix_next;
    logic            we_reg, we_next;
    logic [3:0]      adr_reg, adr_next;
    logic [7:0]      dat_reg, dat_next;
    logic            busy_reg, busy_next;
    logic            err_reg, err_next;

    logic [3:0]      target;
    logic            sel_csr;
    logic [DCOL-1:0] sel_matrix;
    logic            addr_valid;
    logic            request;
    logic            timeout_hit;
    logic [7:0]      count_inc;

    // Address decode: target 0 is the CSR block, targets 1..DCOL map to
    // matrix columns 0..DCOL-1, everything else is unmapped.
    assign target  = wb_adr_i[7:4];
    assign sel_csr = (target == 4'd0);

    genvar gi;
    generate
        for (gi = 0; gi < DCOL; gi++) begin : g_matrix_sel
            assign sel_matrix[gi] = (target == 4'(gi + 1));
        end
    endgenerate

    assign addr_valid  = sel_csr | (|sel_matrix);
    assign request     = wb_cyc_i & wb_stb_i;
    assign timeout_hit = (count_reg >= TIMEOUT_LAST);
    // Saturating increment so a stuck counter can never wrap back to zero.
    assign count_inc   = (count_reg == 8'hFF) ? count_reg : count_reg + 8'd1;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and next-output logic; every output is registered so the
    // targets see clean, glitch-free strobes.
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        stb_csr_next    = stb_csr_reg;
        stb_matrix_next = stb_matrix_reg;
        we_next         = we_reg;
        adr_next        = adr_reg;
        dat_next        = dat_reg;
        busy_next       = busy_reg;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                stb_csr_next    = 1'b0;
                stb_matrix_next = '0;
                busy_next       = 1'b0;
                if (request) begin
                    we_next  = wb_we_i;
                    adr_next = wb_adr_i[3:0];
                    dat_next = wb_dat_to_i;
                    if (addr_valid) begin
                        stb_csr_next    = sel_csr;
                        stb_matrix_next = sel_matrix;
                        busy_next       = 1'b1;
                        count_next      = 8'd0;
                        state_next      = ACTIVE;
                    end else begin
                        // Unmapped target: never strobe anything, just flag it.
                        err_next   = 1'b1;
                        state_next = DONE;
                    end
                end
            end

            ACTIVE: begin
                if (!wb_cyc_i) begin
                    // Host abort takes precedence over ack and timeout.
                    stb_csr_next    = 1'b0;
                    stb_matrix_next = '0;
                    busy_next       = 1'b0;
                    state_next      = IDLE;
                end else if (wb_ack_i) begin
                    // Ack beats a timeout reached in the same cycle.
                    stb_csr_next    = 1'b0;
                    stb_matrix_next = '0;
                    busy_next       = 1'b0;
                    state_next      = DONE;
                end else if (timeout_hit) begin
                    stb_csr_next    = 1'b0;
                    stb_matrix_next = '0;
                    busy_next       = 1'b0;
                    err_next        = 1'b1;
                    state_next      = DONE;
                end else begin
                    count_next = count_inc;
                end
            end

            DONE: begin
                // Wait for the host to release its strobe so a held request is
                // not issued to the target a second time.
                stb_csr_next    = 1'b0;
                stb_matrix_next = '0;
                busy_next       = 1'b0;
                if (!wb_stb_i || !wb_cyc_i) begin
                    state_next = IDLE;
                end
            end

            default: begin
                stb_csr_next    = 1'b0;
                stb_matrix_next = '0;
                busy_next       = 1'b0;
                state_next      = IDLE;
            end
        endcase
    end

    // Output and datapath registers; reset clears every output immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg      <= 8'd0;
            stb_csr_reg    <= 1'b0;
            stb_matrix_reg <= '0;
            we_reg         <= 1'b0;
            adr_reg        <= 4'd0;
            dat_reg        <= 8'd0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            count_reg      <= count_next;
            stb_csr_reg    <= stb_csr_next;
            stb_matrix_reg <= stb_matrix_next;
            we_reg         <= we_next;
            adr_reg        <= adr_next;
            dat_reg        <= dat_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    assign wb_stb_csr_o    = stb_csr_reg;
    assign wb_stb_matrix_o = stb_matrix_reg;
    assign wb_we_o         = we_reg;
    assign wb_adr_o        = adr_reg;
    assign wb_dat_to_o     = dat_reg;
    assign wb_busy_o       = busy_reg;
    assign wb_err_o        = err_reg;

endmodule
